// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic                  REG_WRITE_ENABLE = 1'b1;
  localparam logic [XLEN-1:0]       ZERO_WORD        = '0;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG         = '0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Which writeback source owns the register file write port this cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_A    = 2'd1,
    GRANT_B    = 2'd2
  } grant_e;

  // One-hot decode of a register index into a bitmap position.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input reg_addr_t rd);
    return NUM_REGS'(1) << rd;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request channels (pipeline port A, mul/div port B) plus the
// mul/div issue notification that feeds the pending-destination scoreboard.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN = regfile_wb_arbiter_pkg::XLEN
) ();

  logic            a_valid;
  logic            a_ready;
  reg_addr_t       a_rd;
  logic [XLEN-1:0] a_data;

  logic            b_valid;
  logic            b_ready;
  reg_addr_t       b_rd;
  logic [XLEN-1:0] b_data;

  logic            b_issue;
  reg_addr_t       b_issue_rd;

  // Writeback sources: drive requests, observe grants.
  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output b_issue, b_issue_rd,
    input  a_ready, b_ready
  );

  // Arbiter: observe requests, drive grants.
  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  b_issue, b_issue_rd,
    output a_ready, b_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-destination bitmap for outstanding mul/div writebacks.
// A set and a clear of the same register on one edge leaves the bit set,
// because the set belongs to a newer operation than the write being retired.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_set,
  input  reg_addr_t           i_set_rd,
  input  logic                i_clr,
  input  reg_addr_t           i_clr_rd,
  output logic [NUM_REGS-1:0] o_pending
);

  logic [NUM_REGS-1:0] pending_p0;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] pending_nxt;

  // Next bitmap: clear first, then set, so a same-edge set wins; x0 never pends.
  always_comb begin
    set_mask    = i_set ? rd_onehot(i_set_rd) : '0;
    clr_mask    = i_clr ? rd_onehot(i_clr_rd) : '0;
    pending_nxt = (pending_p0 & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  // Bitmap register, wiped by reset along with all in-flight operations.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      pending_p0 <= '0;
    end else begin
      pending_p0 <= pending_nxt;
    end
  end

  assign o_pending = pending_p0;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) has priority,
// mul/div writeback (B) is forced through after STARVE_LIMIT denied cycles.
// The winning write is registered onto the register file write interface.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = regfile_wb_arbiter_pkg::XLEN
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  regfile_wb_arbiter_if.slave  wb,
  output logic [NUM_REGS-1:0]  o_pending,
  output logic                 o_readwrite,
  output reg_addr_t            o_writereg,
  output logic [XLEN-1:0]      o_writedata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]      starve_cnt_p0;
  logic            force_b;
  grant_e          grant;
  logic            a_xfer;
  logic            b_xfer;
  reg_addr_t       sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            sb_set;

  logic            wr_vld_p1;
  reg_addr_t       wr_rd_p1;
  logic [XLEN-1:0] wr_data_p1;

  // Saturating increment so the counter never runs past the force threshold.
  function automatic logic [3:0] starve_sat_inc(input logic [3:0] cnt);
    if (cnt >= STARVE_MAX) begin
      return STARVE_MAX;
    end
    return cnt + 4'd1;
  endfunction

  // Grant decision from the valids and the starvation count only; reset blocks both.
  always_comb begin
    force_b = wb.b_valid && (starve_cnt_p0 == STARVE_MAX);
    grant   = GRANT_NONE;
    if (!i_reset_n) begin
      grant = GRANT_NONE;
    end else if (wb.a_valid && !force_b) begin
      grant = GRANT_A;
    end else if (wb.b_valid) begin
      grant = GRANT_B;
    end
  end

  assign wb.a_ready = (grant == GRANT_A);
  assign wb.b_ready = (grant == GRANT_B);
  assign a_xfer     = wb.a_valid && wb.a_ready;
  assign b_xfer     = wb.b_valid && wb.b_ready;

  // Select the winning source's destination and data for the output stage.
  always_comb begin
    sel_rd   = ZERO_REG;
    sel_data = XLEN'(ZERO_WORD);
    if (a_xfer) begin
      sel_rd   = wb.a_rd;
      sel_data = wb.a_data;
    end else if (b_xfer) begin
      sel_rd   = wb.b_rd;
      sel_data = wb.b_data;
    end
  end

  // Count consecutive cycles B waits while valid; any grant or idle B restarts it.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      starve_cnt_p0 <= 4'd0;
    end else if (wb.b_valid && !b_xfer) begin
      starve_cnt_p0 <= starve_sat_inc(starve_cnt_p0);
    end else begin
      starve_cnt_p0 <= 4'd0;
    end
  end

  // ---- stage p0 -> p1: register the granted write; x0 writes are swallowed ----
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      wr_vld_p1  <= 1'b0;
      wr_rd_p1   <= ZERO_REG;
      wr_data_p1 <= XLEN'(ZERO_WORD);
    end else if (a_xfer || b_xfer) begin
      wr_vld_p1  <= (sel_rd != ZERO_REG) ? REG_WRITE_ENABLE : 1'b0;
      wr_rd_p1   <= sel_rd;
      wr_data_p1 <= sel_data;
    end else begin
      wr_vld_p1  <= 1'b0;
      wr_rd_p1   <= ZERO_REG;
      wr_data_p1 <= XLEN'(ZERO_WORD);
    end
  end

  assign o_readwrite = wr_vld_p1;
  assign o_writereg  = wr_rd_p1;
  assign o_writedata = wr_data_p1;

  assign sb_set = wb.b_issue && (wb.b_issue_rd != ZERO_REG);

  wb_scoreboard u_scoreboard (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_set     (sb_set),
    .i_set_rd  (wb.b_issue_rd),
    .i_clr     (b_xfer),
    .i_clr_rd  (wb.b_rd),
    .o_pending (o_pending)
  );

  a_one_grant: assert property (@(posedge i_clock) !(wb.a_ready && wb.b_ready));
  a_ready_needs_valid: assert property (@(posedge i_clock)
    (!wb.a_ready || wb.a_valid) && (!wb.b_ready || wb.b_valid));
  a_x0_never_pending: assert property (@(posedge i_clock) o_pending[0] == 1'b0);
  a_starve_bounded: assert property (@(posedge i_clock) starve_cnt_p0 <= STARVE_MAX);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pending;
  logic        readwrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(32)) wb_if ();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(32)) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .wb          (wb_if),
    .o_pending   (pending),
    .o_readwrite (readwrite),
    .o_writereg  (writereg),
    .o_writedata (writedata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int          m_starve  = 0;
  bit [31:0]   m_pending = '0;
  bit          m_we      = 1'b0;
  bit [4:0]    m_rd      = '0;
  bit [31:0]   m_data    = '0;
  bit          exp_ar, exp_br;
  logic        obs_ar, obs_br;

  task automatic drive(input bit rstn, input bit av, input logic [4:0] ard,
                       input logic [31:0] ad, input bit bv, input logic [4:0] brd,
                       input logic [31:0] bd, input bit iss, input logic [4:0] issrd);
    rst_n            = rstn;
    wb_if.a_valid    = av;
    wb_if.a_rd       = ard;
    wb_if.a_data     = ad;
    wb_if.b_valid    = bv;
    wb_if.b_rd       = brd;
    wb_if.b_data     = bd;
    wb_if.b_issue    = iss;
    wb_if.b_issue_rd = issrd;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  // Advance one clock: sample readys mid-cycle, predict grants, update model.
  task automatic tick();
    bit forced;
    @(negedge clk);
    obs_ar = wb_if.a_ready;
    obs_br = wb_if.b_ready;
    if (!rst_n) begin
      exp_ar = 1'b0;
      exp_br = 1'b0;
    end else begin
      forced = wb_if.a_valid && wb_if.b_valid && (m_starve == LIMIT);
      exp_ar = wb_if.a_valid && !forced;
      exp_br = wb_if.b_valid && !exp_ar;
    end
    @(posedge clk);
    if (!rst_n) begin
      m_starve  = 0;
      m_pending = '0;
      m_we = 1'b0; m_rd = '0; m_data = '0;
    end else begin
      if (exp_ar) begin
        m_we = (wb_if.a_rd != 0); m_rd = wb_if.a_rd; m_data = wb_if.a_data;
      end else if (exp_br) begin
        m_we = (wb_if.b_rd != 0); m_rd = wb_if.b_rd; m_data = wb_if.b_data;
      end else begin
        m_we = 1'b0; m_rd = '0; m_data = '0;
      end
      if (wb_if.b_valid && !exp_br) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      else m_starve = 0;
      if (exp_br) m_pending[wb_if.b_rd] = 1'b0;
      if (wb_if.b_issue && wb_if.b_issue_rd != 0) m_pending[wb_if.b_issue_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222, 1'b1, 5'd9);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({obs_ar, obs_br} !== 2'b00) begin
        n_fail++; $display("FAIL reset_readys: got %b required 00", {obs_ar, obs_br});
      end
      n_checks++;
      if ({readwrite, writereg, writedata} !== 38'd0) begin
        n_fail++; $display("FAIL reset_outputs: got %0h required 0", {readwrite, writereg, writedata});
      end
      n_checks++;
      if (pending !== 32'd0) begin
        n_fail++; $display("FAIL reset_pending: got %0h required 0", pending);
      end
    end
    idle();
    tick();
    n_checks++;
    if (pending !== 32'd0 || readwrite !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: pending %0h we %b required 0 0", pending, readwrite);
    end
  endtask

  task automatic test_a_only();
    drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    tick();
    n_checks++;
    if ({obs_ar, obs_br} !== 2'b10) begin
      n_fail++; $display("FAIL a_only_ready: got %b required 10", {obs_ar, obs_br});
    end
    n_checks++;
    if ({readwrite, writereg, writedata} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL a_only_write: got %b %0d %0h required 1 5 deadbeef",
                         readwrite, writereg, writedata);
    end
    idle();
    tick();
    n_checks++;
    if ({readwrite, writereg, writedata} !== 38'd0) begin
      n_fail++; $display("FAIL a_only_after: got %0h required 0", {readwrite, writereg, writedata});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(i + 1), 32'hC0DE_0000 + i, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      tick();
      n_checks++;
      if ({readwrite, writereg, writedata} !== {1'b1, 5'(i + 1), 32'hC0DE_0000 + i}) begin
        n_fail++; $display("FAIL back_to_back[%0d]: got %b %0d %0h required 1 %0d %0h",
                           i, readwrite, writereg, writedata, i + 1, 32'hC0DE_0000 + i);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_contention();
    bit ea, eb;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 5'(10 + i), 32'hA000 + i, 1'b1, 5'd7, 32'h0000_0B07, 1'b0, 5'd0);
      tick();
      ea = (i != 4);
      eb = (i == 4);
      n_checks++;
      if ({obs_ar, obs_br} !== {ea, eb}) begin
        n_fail++; $display("FAIL contention_ready[%0d]: got %b required %b", i, {obs_ar, obs_br}, {ea, eb});
      end
      n_checks++;
      if (eb && {readwrite, writereg, writedata} !== {1'b1, 5'd7, 32'h0000_0B07}) begin
        n_fail++; $display("FAIL contention_b_write: got %b %0d %0h required 1 7 b07",
                           readwrite, writereg, writedata);
      end else if (ea && {readwrite, writereg, writedata} !== {1'b1, 5'(10 + i), 32'hA000 + i}) begin
        n_fail++; $display("FAIL contention_a_write[%0d]: got %b %0d %0h required 1 %0d %0h",
                           i, readwrite, writereg, writedata, 10 + i, 32'hA000 + i);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_scoreboard();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    tick();
    n_checks++;
    if (pending[9] !== 1'b1) begin
      n_fail++; $display("FAIL sb_set: got %b required 1", pending[9]);
    end
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0);
    tick();
    n_checks++;
    if ({obs_br, readwrite, writereg, pending[9]} !== {1'b1, 1'b1, 5'd9, 1'b0}) begin
      n_fail++; $display("FAIL sb_clear: got br %b we %b rd %0d p9 %b required 1 1 9 0",
                         obs_br, readwrite, writereg, pending[9]);
    end
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0999, 1'b1, 5'd9);
    tick();
    n_checks++;
    if ({readwrite, pending[9]} !== 2'b11) begin
      n_fail++; $display("FAIL sb_set_wins: got we %b p9 %b required 1 1", readwrite, pending[9]);
    end
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0999, 1'b0, 5'd0);
    tick();
    n_checks++;
    if (pending !== 32'd0) begin
      n_fail++; $display("FAIL sb_final_clear: got %0h required 0", pending);
    end
    idle();
    tick();
  endtask

  task automatic test_x0();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_0005, 1'b0, 5'd0);
    tick();
    n_checks++;
    if ({obs_br, readwrite} !== 2'b10) begin
      n_fail++; $display("FAIL x0_write: got br %b we %b required 1 0", obs_br, readwrite);
    end
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    tick();
    n_checks++;
    if (pending !== 32'd0) begin
      n_fail++; $display("FAIL x0_issue: got %0h required 0", pending);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
    tick();
    for (int i = 0; i < LIMIT; i++) begin
      drive(1'b1, 1'b1, 5'd1, 32'h1234 + i, 1'b1, 5'd20, 32'h2020, 1'b0, 5'd0);
      tick();
    end
    n_checks++;
    if (pending !== 32'h0000_1008) begin
      n_fail++; $display("FAIL mid_pre_pending: got %0h required 1008", pending);
    end
    drive(1'b0, 1'b1, 5'd1, 32'h5555, 1'b1, 5'd20, 32'h2020, 1'b0, 5'd0);
    tick();
    n_checks++;
    if ({obs_ar, obs_br} !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset_readys: got %b required 00", {obs_ar, obs_br});
    end
    n_checks++;
    if ({pending, readwrite, writereg, writedata} !== 70'd0) begin
      n_fail++; $display("FAIL mid_reset_state: got pending %0h we %b rd %0d data %0h required all 0",
                         pending, readwrite, writereg, writedata);
    end
    drive(1'b1, 1'b1, 5'd2, 32'h6666, 1'b1, 5'd20, 32'h2020, 1'b0, 5'd0);
    tick();
    n_checks++;
    if ({obs_ar, obs_br} !== 2'b10) begin
      n_fail++; $display("FAIL mid_starve_cleared: got %b required 10", {obs_ar, obs_br});
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0),
            $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom));
      tick();
      n_checks++;
      if ({obs_ar, obs_br} !== {exp_ar, exp_br}) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b required %b", i, {obs_ar, obs_br}, {exp_ar, exp_br});
      end
      n_checks++;
      if ({readwrite, writereg, writedata} !== {m_we, m_rd, m_data}) begin
        n_fail++; $display("FAIL rand_write[%0d]: got %b %0d %0h required %b %0d %0h",
                           i, readwrite, writereg, writedata, m_we, m_rd, m_data);
      end
      n_checks++;
      if (pending !== m_pending) begin
        n_fail++; $display("FAIL rand_pending[%0d]: got %0h required %0h", i, pending, m_pending);
      end
    end
    idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    test_reset();
    test_a_only();
    test_back_to_back();
    test_contention();
    test_scoreboard();
    test_x0();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
